// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: host, instruction-memory and control-unit signals of the instruction sequencer
//   START/PROG_BASE         host starts a program at PROG_BASE
//   BUSY/FINISH/ERR         status back to the host
//   IMEM_RD/IMEM_ADDR       read request to synchronous instruction memory
//   IMEM_DATA               read data, valid the cycle after IMEM_RD
//   INSTR/ONSWT             instruction word and enable to the control unit
//   DONE/OFFSWT             control-unit completion and halt acknowledge
//   master: sequencer side; slave: host/memory/control-unit side
interface instr_sequencer_if #(
   parameter int AW = 8
) ();
   logic          START;
   logic [AW-1:0] PROG_BASE;
   logic          BUSY;
   logic          FINISH;
   logic          ERR;
   logic          IMEM_RD;
   logic [AW-1:0] IMEM_ADDR;
   logic [31:0]   IMEM_DATA;
   logic [31:0]   INSTR;
   logic          ONSWT;
   logic          DONE;
   logic          OFFSWT;
   modport master (
      input  START, PROG_BASE, IMEM_DATA, DONE, OFFSWT,
      output BUSY, FINISH, ERR, IMEM_RD, IMEM_ADDR, INSTR, ONSWT
   );
   modport slave (
      output START, PROG_BASE, IMEM_DATA, DONE, OFFSWT,
      input  BUSY, FINISH, ERR, IMEM_RD, IMEM_ADDR, INSTR, ONSWT
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues instruction words from a synchronous memory to the control unit
//   CLK    clock
//   RSTN   synchronous active-low reset
//   bus    instr_sequencer_if.master: host START/PROG_BASE in, BUSY/FINISH/ERR out;
//          IMEM_RD/IMEM_ADDR out, IMEM_DATA in; INSTR/ONSWT out, DONE/OFFSWT in
// Word format: [2:0] opcode (0..4 legal), [6:3] index, [7] halt flag with opcode 0,
// [31:8] passed through untouched.
module instr_sequencer #(
   parameter int AW      = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RSTN,
   instr_sequencer_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_GUARD, S_WAIT, S_HALT} state_t;
   localparam int CW = $clog2(TIMEOUT);
   state_t        state;
   logic [AW-1:0] pc;
   logic [31:0]   nxt;
   logic [CW-1:0] cnt;
   logic          mem_bad, nxt_bad, nxt_halt, cnt_end;
   assign mem_bad  = bus.IMEM_DATA[2:0] > 3'd4;
   assign nxt_bad  = nxt[2:0] > 3'd4;
   assign nxt_halt = nxt[2:0] == 3'd0 && nxt[7];
   assign cnt_end  = cnt == CW'(TIMEOUT - 1);
   // Reads are launched on the edge that enters the requesting state, so IMEM_RD is
   // high during S_ISSUE and the prefetched word is on IMEM_DATA during S_GUARD.
   // The first read launches from S_IDLE, so S_LOAD waits one extra cycle for its data
   // (IMEM_RD low again marks the cycle the data is valid).
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state         <= S_IDLE;
         pc            <= '0;
         nxt           <= '0;
         cnt           <= '0;
         bus.INSTR     <= '0;
         bus.IMEM_RD   <= 1'b0;
         bus.IMEM_ADDR <= '0;
         bus.FINISH    <= 1'b0;
         bus.ERR       <= 1'b0;
         bus.BUSY      <= 1'b0;
         bus.ONSWT     <= 1'b0;
      end else begin
         bus.IMEM_RD <= 1'b0;
         bus.FINISH  <= 1'b0;
         cnt         <= cnt + CW'(1);
         case (state)
            S_IDLE: if (bus.START) begin
               pc            <= bus.PROG_BASE;
               bus.IMEM_RD   <= 1'b1;
               bus.IMEM_ADDR <= bus.PROG_BASE;
               bus.ERR       <= 1'b0;
               bus.BUSY      <= 1'b1;
               bus.ONSWT     <= 1'b1;
               state         <= S_LOAD;
            end
            S_LOAD: if (!bus.IMEM_RD) begin
               nxt <= bus.IMEM_DATA;
               if (mem_bad) begin
                  bus.ERR   <= 1'b1;
                  bus.INSTR <= '0;
                  bus.BUSY  <= 1'b0;
                  bus.ONSWT <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  bus.IMEM_RD   <= 1'b1;
                  bus.IMEM_ADDR <= pc + AW'(1);
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               bus.INSTR <= nxt;
               pc        <= pc + AW'(1);
               cnt       <= '0;
               state     <= nxt_halt ? S_HALT : S_GUARD;
            end
            // DONE here still belongs to the previous word and is deliberately ignored.
            S_GUARD: begin
               nxt   <= bus.IMEM_DATA;
               cnt   <= '0;
               state <= S_WAIT;
            end
            // On DONE the next word replaces INSTR directly, never passing through 0.
            S_WAIT: if (bus.DONE && !nxt_bad) begin
               bus.IMEM_RD   <= 1'b1;
               bus.IMEM_ADDR <= pc + AW'(1);
               state         <= S_ISSUE;
            end else if (bus.DONE || cnt_end) begin
               bus.ERR   <= 1'b1;
               bus.INSTR <= '0;
               bus.BUSY  <= 1'b0;
               bus.ONSWT <= 1'b0;
               state     <= S_IDLE;
            end
            S_HALT: if (bus.OFFSWT || cnt_end) begin
               bus.FINISH <= bus.OFFSWT;
               bus.ERR    <= !bus.OFFSWT;
               bus.INSTR  <= '0;
               bus.BUSY   <= 1'b0;
               bus.ONSWT  <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
